// File: rtl/switch_event_arbiter_pkg.sv
// Shared event-type codes and state encodings for the switch event arbiter
// and its hold timer.
package switch_event_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_LONG    = 2'b10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } out_state_t;

    typedef enum logic [1:0] {
        T_IDLE = 2'b00,
        T_RUN  = 2'b01,
        T_DONE = 2'b10
    } timer_state_t;

endpackage

// File: rtl/switch_event_arbiter_if.sv
// Event delivery bus: valid/ready handshake carrying switch id and event type,
// plus the overwrite-drop pulse.
interface switch_event_arbiter_if #(
    parameter int NUM_SWITCHES = 4
);
    localparam int ID_W = $clog2(NUM_SWITCHES);

    logic            o_Event_Valid;
    logic            i_Event_Ready;
    logic [ID_W-1:0] o_Event_Id;
    logic [1:0]      o_Event_Type;
    logic            o_Drop;

    modport master (
        output o_Event_Valid,
        output o_Event_Id,
        output o_Event_Type,
        output o_Drop,
        input  i_Event_Ready
    );

    modport slave (
        input  o_Event_Valid,
        input  o_Event_Id,
        input  o_Event_Type,
        input  o_Drop,
        output i_Event_Ready
    );
endinterface

// File: rtl/switch_event_arbiter_hold_timer.sv
// Single long-press timer shared by all switches; the most recent press owns it
// and the strobe fires combinationally so the slot is set on the terminal edge.
module switch_hold_timer
    import switch_event_pkg::*;
#(
    parameter int NUM_SWITCHES     = 4,
    parameter int LONG_PRESS_LIMIT = 12_500_000,
    localparam int ID_W            = $clog2(NUM_SWITCHES)
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_SWITCHES-1:0] press_s,
    input  logic [NUM_SWITCHES-1:0] release_s,
    output logic                    long_stb_s,
    output logic [ID_W-1:0]         owner_r
);
    localparam int CNT_W                = $clog2(LONG_PRESS_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_PRESS_LIMIT - 1);

    timer_state_t    state_r;
    logic [CNT_W-1:0] count_r;
    logic [ID_W-1:0]  first_press_s;
    logic             any_press_s;
    logic             owner_rel_s;

    // Lowest-index press edge wins ownership
    always_comb begin
        first_press_s = '0;
        any_press_s   = 1'b0;
        for (int i = NUM_SWITCHES - 1; i >= 0; i--) begin
            if (press_s[i]) begin
                first_press_s = ID_W'(i);
                any_press_s   = 1'b1;
            end else begin
                first_press_s = first_press_s;
                any_press_s   = any_press_s;
            end
        end
    end

    assign owner_rel_s = release_s[owner_r];
    // An owner release on the terminal cycle cancels the long-press
    assign long_stb_s  = (state_r == T_RUN) && (count_r == CNT_LAST) && !owner_rel_s;

    // Timer FSM: press re-arms, owner release stops, terminal count parks in T_DONE
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r <= T_IDLE;
            owner_r <= '0;
            count_r <= '0;
        end else if (any_press_s) begin
            state_r <= T_RUN;
            owner_r <= first_press_s;
            count_r <= '0;
        end else if (owner_rel_s) begin
            state_r <= T_IDLE;
            count_r <= '0;
        end else begin
            case (state_r)
                T_RUN: begin
                    if (count_r == CNT_LAST) begin
                        state_r <= T_DONE;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                T_IDLE:  state_r <= T_IDLE;
                T_DONE:  state_r <= T_DONE;
                default: state_r <= T_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/switch_event_arbiter.sv
// Turns debounced switch levels into press/release/long-press events and
// delivers them one at a time, round-robin, over a valid/ready bus.
module switch_event_arbiter
    import switch_event_pkg::*;
#(
    parameter int NUM_SWITCHES     = 4,
    parameter int LONG_PRESS_LIMIT = 12_500_000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    switch_event_arbiter_if.master  evt_bus
);
    localparam int ID_W = $clog2(NUM_SWITCHES);

    logic [NUM_SWITCHES-1:0]       prev_r;
    logic [NUM_SWITCHES-1:0]       press_s;
    logic [NUM_SWITCHES-1:0]       release_s;
    logic                          long_stb_s;
    logic [ID_W-1:0]               owner_s;

    logic [NUM_SWITCHES-1:0]       pend_r;
    logic [NUM_SWITCHES-1:0][1:0]  slot_type_r;
    logic [NUM_SWITCHES-1:0]       new_evt_s;
    logic [NUM_SWITCHES-1:0][1:0]  new_type_s;
    logic [NUM_SWITCHES-1:0]       grant_hit_s;
    logic [NUM_SWITCHES-1:0]       drop_vec_s;

    logic [ID_W-1:0]               ptr_r;
    logic [ID_W-1:0]               next_ptr_s;
    logic [ID_W-1:0]               grant_id_s;
    logic                          grant_found_s;
    logic                          accept_s;
    logic                          load_s;

    out_state_t                    state_r;
    logic                          valid_r;
    logic [ID_W-1:0]               id_r;
    logic [1:0]                    type_r;
    logic                          drop_r;

    // Previous switch levels for edge detection; zero at reset
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            prev_r <= '0;
        end else begin
            prev_r <= i_Switch;
        end
    end

    assign press_s   = i_Switch & ~prev_r;
    assign release_s = ~i_Switch & prev_r;

    switch_hold_timer #(
        .NUM_SWITCHES    (NUM_SWITCHES),
        .LONG_PRESS_LIMIT(LONG_PRESS_LIMIT)
    ) u_hold_timer (
        .i_Clk     (i_Clk),
        .i_Rst_L   (i_Rst_L),
        .press_s   (press_s),
        .release_s (release_s),
        .long_stb_s(long_stb_s),
        .owner_r   (owner_s)
    );

    // Round-robin search over the registered pending bits, starting at ptr_r
    always_comb begin
        logic [ID_W:0] sum_v;
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        for (int i = 0; i < NUM_SWITCHES; i++) begin
            sum_v = {1'b0, ptr_r} + (ID_W + 1)'(i);
            if (sum_v >= (ID_W + 1)'(NUM_SWITCHES)) begin
                sum_v = sum_v - (ID_W + 1)'(NUM_SWITCHES);
            end else begin
                sum_v = sum_v;
            end
            if (!grant_found_s && pend_r[sum_v[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_id_s    = sum_v[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
                grant_id_s    = grant_id_s;
            end
        end
    end

    // Pointer advances to the slot after the one just granted
    always_comb begin
        logic [ID_W:0] inc_v;
        inc_v = {1'b0, grant_id_s} + (ID_W + 1)'(1);
        if (inc_v >= (ID_W + 1)'(NUM_SWITCHES)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = inc_v[ID_W-1:0];
        end
    end

    assign accept_s = valid_r && evt_bus.i_Event_Ready;
    assign load_s   = grant_found_s && ((state_r == ST_IDLE) || accept_s);

    // Per-slot new events; edge events take priority over a long-press
    always_comb begin
        new_evt_s   = '0;
        new_type_s  = '0;
        grant_hit_s = '0;
        drop_vec_s  = '0;
        for (int s = 0; s < NUM_SWITCHES; s++) begin
            if (press_s[s]) begin
                new_evt_s[s]  = 1'b1;
                new_type_s[s] = EVT_PRESS;
            end else if (release_s[s]) begin
                new_evt_s[s]  = 1'b1;
                new_type_s[s] = EVT_RELEASE;
            end else if (long_stb_s && (owner_s == ID_W'(s))) begin
                new_evt_s[s]  = 1'b1;
                new_type_s[s] = EVT_LONG;
            end else begin
                new_evt_s[s]  = 1'b0;
                new_type_s[s] = EVT_PRESS;
            end
            grant_hit_s[s] = load_s && (grant_id_s == ID_W'(s));
            drop_vec_s[s]  = new_evt_s[s] && pend_r[s] && !grant_hit_s[s];
        end
    end

    // Pending slots, round-robin pointer and registered drop pulse
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            pend_r      <= '0;
            slot_type_r <= '0;
            ptr_r       <= '0;
            drop_r      <= 1'b0;
        end else begin
            for (int s = 0; s < NUM_SWITCHES; s++) begin
                if (new_evt_s[s]) begin
                    pend_r[s]      <= 1'b1;
                    slot_type_r[s] <= new_type_s[s];
                end else if (grant_hit_s[s]) begin
                    pend_r[s]      <= 1'b0;
                end else begin
                    pend_r[s]      <= pend_r[s];
                end
            end
            if (load_s) begin
                ptr_r <= next_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
            drop_r <= |drop_vec_s;
        end
    end

    // Output FSM; a grant on accept reloads in place so there is no bubble
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            id_r    <= '0;
            type_r  <= EVT_PRESS;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        state_r <= ST_PRESENT;
                        valid_r <= 1'b1;
                        id_r    <= grant_id_s;
                        type_r  <= slot_type_r[grant_id_s];
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_PRESENT: begin
                    if (accept_s && load_s) begin
                        id_r    <= grant_id_s;
                        type_r  <= slot_type_r[grant_id_s];
                    end else if (accept_s) begin
                        state_r <= ST_IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign evt_bus.o_Event_Valid = valid_r;
    assign evt_bus.o_Event_Id    = id_r;
    assign evt_bus.o_Event_Type  = type_r;
    assign evt_bus.o_Drop        = drop_r;

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Directed bench for switch_event_arbiter with 4 switches and a long-press
// limit of 8 cycles; expected events are worked out by hand per step.
module tb_switch_event_arbiter;
    import switch_event_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    int         vectors;
    int         miscompares;

    switch_event_arbiter_if #(.NUM_SWITCHES(4)) bus ();

    switch_event_arbiter #(
        .NUM_SWITCHES    (4),
        .LONG_PRESS_LIMIT(8)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .i_Switch(sw),
        .evt_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ev(input string tag, input logic v, input logic [1:0] id, input logic [1:0] ty);
        chk({tag, "_valid"}, {31'd0, bus.o_Event_Valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_id"}, {30'd0, bus.o_Event_Id}, {30'd0, id});
            chk({tag, "_type"}, {30'd0, bus.o_Event_Type}, {30'd0, ty});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // 1: reset released with switch 1 already high
        rst_n = 1'b0;
        sw = 4'b0010;
        bus.i_Event_Ready = 1'b1;
        #12;
        chk("rst_valid", {31'd0, bus.o_Event_Valid}, 32'd0);
        chk("rst_id", {30'd0, bus.o_Event_Id}, 32'd0);
        chk("rst_type", {30'd0, bus.o_Event_Type}, 32'd0);
        chk("rst_drop", {31'd0, bus.o_Drop}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(); ev("t1_e1", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t1_e2", 1'b1, 2'd1, EVT_PRESS);
        tick(); ev("t1_e3", 1'b0, 2'd0, EVT_PRESS);
        sw = 4'b0000;
        tick(); ev("t1_rel0", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t1_rel1", 1'b1, 2'd1, EVT_RELEASE);
        tick(); ev("t1_rel2", 1'b0, 2'd0, EVT_PRESS);

        // 6: asynchronous reset while presenting with two slots pending
        bus.i_Event_Ready = 1'b0;
        sw = 4'b0111;
        tick(); ev("t6_e0", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t6_e1", 1'b1, 2'd2, EVT_PRESS);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {31'd0, bus.o_Event_Valid}, 32'd0);
        chk("t6_async_id", {30'd0, bus.o_Event_Id}, 32'd0);
        sw = 4'b0000;
        tick();
        tick();
        #3 rst_n = 1'b1;
        bus.i_Event_Ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); ev("t6_nostale", 1'b0, 2'd0, EVT_PRESS);
        end

        // 2: simultaneous presses under back-pressure, then drain
        bus.i_Event_Ready = 1'b0;
        sw = 4'b1101;
        tick(); ev("t2_a0", 1'b0, 2'd0, EVT_PRESS);
        for (int k = 1; k <= 5; k++) begin
            tick(); ev("t2_hold", 1'b1, 2'd0, EVT_PRESS);
            chk("t2_hold_drop", {31'd0, bus.o_Drop}, 32'd0);
        end
        bus.i_Event_Ready = 1'b1;
        tick(); ev("t2_a6", 1'b1, 2'd2, EVT_PRESS);
        tick(); ev("t2_a7", 1'b1, 2'd3, EVT_PRESS);
        tick(); ev("t2_a8", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t2_a9_long", 1'b1, 2'd0, EVT_LONG);
        tick(); ev("t2_a10", 1'b0, 2'd0, EVT_PRESS);
        sw = 4'b0000;
        tick(); ev("t2_b0", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t2_b1", 1'b1, 2'd2, EVT_RELEASE);
        tick(); ev("t2_b2", 1'b1, 2'd3, EVT_RELEASE);
        tick(); ev("t2_b3", 1'b1, 2'd0, EVT_RELEASE);
        tick(); ev("t2_b4", 1'b0, 2'd0, EVT_PRESS);

        // 3: long-press on switch 1 held for 12 cycles
        sw = 4'b0010;
        tick(); ev("t3_p0", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t3_p1", 1'b1, 2'd1, EVT_PRESS);
        for (int k = 2; k <= 7; k++) begin
            tick(); ev("t3_wait", 1'b0, 2'd0, EVT_PRESS);
        end
        tick(); ev("t3_p8", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t3_p9_long", 1'b1, 2'd1, EVT_LONG);
        tick(); ev("t3_p10", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t3_p11", 1'b0, 2'd0, EVT_PRESS);
        sw = 4'b0000;
        tick(); ev("t3_p12", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t3_rel", 1'b1, 2'd1, EVT_RELEASE);
        tick(); ev("t3_end", 1'b0, 2'd0, EVT_PRESS);

        // 4a: owner release on the terminal-count cycle suppresses long-press
        sw = 4'b0100;
        tick(); ev("t4a_q0", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t4a_q1", 1'b1, 2'd2, EVT_PRESS);
        for (int k = 2; k <= 7; k++) begin
            tick(); ev("t4a_wait", 1'b0, 2'd0, EVT_PRESS);
        end
        sw = 4'b0000;
        tick(); ev("t4a_q8", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t4a_rel", 1'b1, 2'd2, EVT_RELEASE);
        for (int k = 0; k < 4; k++) begin
            tick(); ev("t4a_nolong", 1'b0, 2'd0, EVT_PRESS);
        end

        // 4b: switch 3 steals the timer from switch 0
        sw = 4'b0001;
        tick(); ev("t4b_r0", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t4b_r1", 1'b1, 2'd0, EVT_PRESS);
        tick(); ev("t4b_r2", 1'b0, 2'd0, EVT_PRESS);
        sw = 4'b1001;
        tick(); ev("t4b_r3", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t4b_r4", 1'b1, 2'd3, EVT_PRESS);
        for (int k = 5; k <= 11; k++) begin
            tick(); ev("t4b_nolong0", 1'b0, 2'd0, EVT_PRESS);
        end
        tick(); ev("t4b_long3", 1'b1, 2'd3, EVT_LONG);
        tick(); ev("t4b_r13", 1'b0, 2'd0, EVT_PRESS);
        sw = 4'b0000;
        tick(); ev("t4b_s0", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t4b_s1", 1'b1, 2'd0, EVT_RELEASE);
        tick(); ev("t4b_s2", 1'b1, 2'd3, EVT_RELEASE);
        tick(); ev("t4b_s3", 1'b0, 2'd0, EVT_PRESS);

        // 5: press then release of switch 0 while it waits behind switch 1
        bus.i_Event_Ready = 1'b0;
        sw = 4'b0010;
        tick(); ev("t5_t0", 1'b0, 2'd0, EVT_PRESS);
        sw = 4'b0011;
        tick(); ev("t5_t1", 1'b1, 2'd1, EVT_PRESS);
        chk("t5_t1_drop", {31'd0, bus.o_Drop}, 32'd0);
        sw = 4'b0010;
        tick(); ev("t5_t2", 1'b1, 2'd1, EVT_PRESS);
        chk("t5_t2_drop", {31'd0, bus.o_Drop}, 32'd1);
        tick(); ev("t5_t3", 1'b1, 2'd1, EVT_PRESS);
        chk("t5_t3_drop", {31'd0, bus.o_Drop}, 32'd0);
        bus.i_Event_Ready = 1'b1;
        tick(); ev("t5_t4", 1'b1, 2'd0, EVT_RELEASE);
        tick(); ev("t5_t5", 1'b0, 2'd0, EVT_PRESS);
        sw = 4'b0000;
        tick(); ev("t5_t6", 1'b0, 2'd0, EVT_PRESS);
        tick(); ev("t5_t7", 1'b1, 2'd1, EVT_RELEASE);
        tick(); ev("t5_t8", 1'b0, 2'd0, EVT_PRESS);
        chk("t5_t8_drop", {31'd0, bus.o_Drop}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
